// File: rtl/core_gated_pulse_gen.sv
// core_gated_pulse_gen
//   Emits exactly N single-cycle pulses spread evenly over a gate of G clock
//   cycles, using a Bresenham accumulator for spacing. N is clamped to G.
// Ports:
//   clk         system clock, posedge
//   rst_n       asynchronous active-low reset
//   start_i     1-cycle request, sampled only when idle
//   abort_i     synchronous abort of a running gate
//   cnt_in_i    requested pulse count N
//   gate_len_i  gate length G in clk cycles
//   out_o       registered pulse output, 1 cycle high per pulse
//   busy_o      high while the gate runs
//   done_o      1-cycle strobe at normal gate end
//   emitted_o   pulses emitted in the current/last gate
module core_gated_pulse_gen #(
    parameter int unsigned W_CTR  = 8,
    parameter int unsigned W_GATE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [W_CTR-1:0]  cnt_in_i,
    input  logic [W_GATE-1:0] gate_len_i,
    output logic              out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [W_CTR-1:0]  emitted_o
);

    localparam int unsigned W_MAX = (W_CTR > W_GATE) ? W_CTR : W_GATE;
    // One extra bit: acc < G and N <= G, so acc + N < 2*G always fits.
    localparam int unsigned W_ACC = W_MAX + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [W_CTR-1:0]    n_q, n_d;
    logic [W_GATE-1:0]   g_q, g_d;
    logic [W_ACC-1:0]    acc_q, acc_d;
    logic [W_GATE-1:0]   step_q, step_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [W_CTR-1:0]    emitted_q, emitted_d;

    logic [W_CTR-1:0]    n_start;
    logic [W_ACC-1:0]    acc_sum;
    logic [W_ACC-1:0]    first_sum;

    // Clamped request count, evaluated against the live inputs at start.
    always_comb begin
        if (W_MAX'(cnt_in_i) > W_MAX'(gate_len_i)) begin
            n_start = W_CTR'(gate_len_i);
        end else begin
            n_start = cnt_in_i;
        end
    end

    assign acc_sum   = acc_q + W_ACC'(n_q);
    assign first_sum = W_ACC'(n_start);

    // Next-state and output logic. Step 1 is evaluated on the accepting
    // edge so its pulse appears in the first busy cycle.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        g_d       = g_q;
        acc_d     = acc_q;
        step_d    = step_q;
        out_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        emitted_d = emitted_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d       = n_start;
                    g_d       = gate_len_i;
                    acc_d     = '0;
                    step_d    = '0;
                    emitted_d = '0;
                    if (gate_len_i == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        step_d  = W_GATE'(1);
                        if (first_sum >= W_ACC'(gate_len_i)) begin
                            acc_d     = first_sum - W_ACC'(gate_len_i);
                            out_d     = 1'b1;
                            emitted_d = W_CTR'(1);
                        end else begin
                            acc_d = first_sum;
                        end
                    end
                end
            end

            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (step_q == g_q) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + W_GATE'(1);
                    if (acc_sum >= W_ACC'(g_q)) begin
                        acc_d     = acc_sum - W_ACC'(g_q);
                        out_d     = 1'b1;
                        emitted_d = emitted_q + W_CTR'(1);
                    end else begin
                        acc_d = acc_sum;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            g_q       <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            emitted_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            g_q       <= g_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            emitted_q <= emitted_d;
        end
    end

    assign out_o     = out_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign emitted_o = emitted_q;

endmodule

// File: tb/tb_core_gated_pulse_gen.sv
// tb_core_gated_pulse_gen
//   Scoreboard bench: per-cycle expected {out, busy, done, emitted} records
//   are queued from a floor-division pulse model when a gate is started, and
//   popped and compared once per cycle while the gate plays out.
module tb_core_gated_pulse_gen;

    typedef struct packed {
        logic       out;
        logic       busy;
        logic       done;
        logic [7:0] emitted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  cnt_in;
    logic [15:0] gate_len;
    logic        out_w;
    logic        busy_w;
    logic        done_w;
    logic [7:0]  emitted_w;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    core_gated_pulse_gen #(.W_CTR(8), .W_GATE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .cnt_in_i   (cnt_in),
        .gate_len_i (gate_len),
        .out_o      (out_w),
        .busy_o     (busy_w),
        .done_o     (done_w),
        .emitted_o  (emitted_w)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o = {out_w, busy_w, done_w, emitted_w};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start one gate, build its expected trace, then play it out cycle by cycle.
    task automatic run_gate(input int n, input int g, input int abort_at,
                            input bit busy_start, input bit fin_start,
                            input bit abort_with_start);
        int   nq;
        int   cum;
        int   c;
        int   fin_c;
        bit   pulse;
        exp_t e;
        nq  = (n < g) ? n : g;
        cum = 0;
        if (g == 0) begin
            exp_q.push_back('{out: 1'b0, busy: 1'b0, done: 1'b1, emitted: 8'd0});
            exp_q.push_back('{out: 1'b0, busy: 1'b0, done: 1'b0, emitted: 8'd0});
        end else begin
            for (int k = 1; k <= g; k++) begin
                if (abort_at != 0 && k > abort_at) break;
                pulse = ((k * nq) / g) > (((k - 1) * nq) / g);
                if (pulse) cum++;
                exp_q.push_back('{out: pulse, busy: 1'b1, done: 1'b0, emitted: 8'(cum)});
            end
            if (abort_at != 0) begin
                exp_q.push_back('{out: 1'b0, busy: 1'b0, done: 1'b0, emitted: 8'(cum)});
            end else begin
                exp_q.push_back('{out: 1'b0, busy: 1'b0, done: 1'b1, emitted: 8'(cum)});
                exp_q.push_back('{out: 1'b0, busy: 1'b0, done: 1'b0, emitted: 8'(cum)});
            end
        end
        fin_c = (g == 0) ? 1 : g + 1;

        @(negedge clk);
        start    = 1'b1;
        cnt_in   = 8'(n);
        gate_len = 16'(g);
        abort    = abort_with_start;
        @(posedge clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        cnt_in   = 8'($urandom);
        gate_len = 16'($urandom);
        c = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("n%0d_g%0d_c%0d", n, g, c), 32'(observed()), 32'(e));
            if (abort_at == c) abort = 1'b1;
            if (busy_start && c == 2) begin
                start    = 1'b1;
                cnt_in   = 8'd1;
                gate_len = 16'd1;
            end
            if (fin_start && abort_at == 0 && c == fin_c) begin
                start    = 1'b1;
                cnt_in   = 8'd2;
                gate_len = 16'd2;
            end
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
            c++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        cnt_in   = '0;
        gate_len = '0;
        #3;
        chk("reset", 32'(observed()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_gate(4, 8, 0, 1'b0, 1'b0, 1'b0);
        run_gate(8, 8, 0, 1'b0, 1'b0, 1'b0);
        run_gate(200, 10, 0, 1'b0, 1'b0, 1'b0);
        chk("clamp_emitted", 32'(emitted_w), 32'd10);
        run_gate(0, 5, 0, 1'b0, 1'b0, 1'b0);
        run_gate(3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_gate(3, 6, 3, 1'b1, 1'b0, 1'b0);
        chk("abort_emitted", 32'(emitted_w), 32'd1);
        run_gate(5, 7, 0, 1'b0, 1'b1, 1'b0);
        run_gate(2, 4, 0, 1'b0, 1'b0, 1'b1);
        run_gate(3, 0, 0, 1'b0, 1'b1, 1'b0);
        run_gate(7, 7, 7, 1'b0, 1'b0, 1'b0);

        // Abort while idle leaves everything untouched.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort", 32'(observed()), 32'(exp_t'({1'b0, 1'b0, 1'b0, 8'd7})));

        for (int i = 0; i < 6; i++) begin
            run_gate(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                     0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a dense gate.
        @(negedge clk);
        start    = 1'b1;
        cnt_in   = 8'd8;
        gate_len = 16'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst", 32'(observed()), 32'(exp_t'({1'b1, 1'b1, 1'b0, 8'd2})));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(observed()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(observed()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
